sram_responder: RTL and testbench
=================================

// Module: sram_responder
//
// PURPOSE
// Memory-side responder for the SLC-3 CPU memory bus. Answers the control unit's active-low
// Mem_CE/Mem_OE/Mem_WE/Mem_UB/Mem_LB strobes from on-chip RAM.
// Read data is valid in the 2nd cycle of an OE-low run, so the CPU's LD_MDR in that cycle captures it.
// Writes commit after a 2-cycle WE-low run.
// Also decodes one memory-mapped I/O word: reads return switches, writes update the hex display register.
//
// PARAMETERS
// DEPTH_LOG2  10        RAM depth = 2**DEPTH_LOG2 words. Only the low DEPTH_LOG2 address bits index RAM (aliasing).
// DATA_W      16        word width; must be even (two byte lanes)
// IO_ADDR     16'hFFFF  MMIO address: read -> Switches, write -> Hex_out; never touches RAM
//
// PORTS
// Clk            in   1       clock
// Reset          in   1       synchronous, active-high reset
// ADDR           in   16      word address (from MAR)
// Data_to_mem    in   DATA_W  write data (from MDR)
// Mem_CE         in   1       chip enable, active low
// Mem_OE         in   1       read strobe, active low
// Mem_WE         in   1       write strobe, active low
// Mem_UB         in   1       upper byte enable [DATA_W-1:DATA_W/2], active low
// Mem_LB         in   1       lower byte enable [DATA_W/2-1:0], active low
// Switches       in   DATA_W  board switches, read at IO_ADDR
// Data_from_mem  out  DATA_W  read data, registered
// Hex_out        out  DATA_W  hex display register, written at IO_ADDR
// Rd_valid       out  1       high while Data_from_mem holds data for the current OE-low run
// Wr_done        out  1       1-cycle pulse in the cycle after a write commits
// Bus_err        out  1       1-cycle pulse when OE and WE are sampled low together with CE low
//
// BEHAVIOUR
// - Reset values (next edge with Reset=1):
//   - Outputs: Data_from_mem=0, Hex_out=0, Rd_valid=0, Wr_done=0, Bus_err=0.
//   - State=IDLE.
//   - RAM contents are not cleared.
// - States: IDLE, RD, WR1, WR_HOLD. All transitions occur at the posedge.
//   - When an edge samples CE=1, next state is IDLE and no access occurs, whatever OE/WE are.
//   - IDLE:
//     - OE=0, WE=1 -> RD. Read data is captured on the same edge.
//     - WE=0 -> WR1. ADDR, Data_to_mem, UB and LB are latched.
//     - OE=0 with WE=0 -> WR1 and Bus_err pulses. The write has priority.
//   - RD:
//     - Rd_valid=1.
//     - While OE=0, stays in RD and recaptures data each edge, so output tracks ADDR with 1-cycle latency.
//     - On an edge that samples OE=1, goes to IDLE and Rd_valid falls.
//     - If WE=0 is sampled, behaves as from IDLE.
//   - WR1:
//     - WE still 0: commit the latched word, RAM or Hex_out. Only lanes whose UB/LB were low are written.
//       Then go to WR_HOLD and pulse Wr_done the next cycle.
//     - WE=1: abort, no commit, go to IDLE. A single-cycle WE is a non-write.
//   - WR_HOLD: no further commit while WE=0. Goes to IDLE on the edge that samples WE=1.
//     Exactly one commit per WE-low run.
// - Read capture:
//   - ADDR==IO_ADDR -> Data_from_mem=Switches.
//   - Otherwise -> RAM[ADDR[DEPTH_LOG2-1:0]].
//   - Byte enables are ignored on reads; the full word is returned.
// - Data_from_mem holds its last value outside reads. Rd_valid qualifies it.
// - Read-after-write to the same address in back-to-back runs returns the newly written data.
//   No bypass is needed: the commit precedes the next capture edge.
// - Reset asserted in WR1 suppresses the commit at that edge. Reset in RD drops Rd_valid next cycle.
// - Hex_out changes only on an IO_ADDR write commit, respecting byte lanes.
//
// TESTING
// 1. Reset, then an OE-low run for 2 cycles at addr 0x0003.
//    -> Rd_valid=1 in cycle 2, Data_from_mem=RAM[3] in cycle 2.
//    -> Rd_valid=0 after OE rises.
// 2. WE low 2 cycles at addr 0x0010, data 0xBEEF, UB=LB=0.
//    -> Wr_done pulse; subsequent read returns 0xBEEF.
//    Then write 0x1234 with UB=1, LB=0 -> readback 0xBE34.
// 3. WE low 1 cycle at 0x0020 with data 0xAAAA -> no Wr_done; RAM[0x20] unchanged.
//    WE low 5 cycles -> exactly one Wr_done.
// 4. Switches=0x5A5A, OE run at 0xFFFF -> Data_from_mem=0x5A5A.
//    Write 0x00C3 at 0xFFFF -> Hex_out=0x00C3; RAM[0x3FF] unchanged.
// 5. OE=WE=0, CE=0 at 0x0040, data 0x7777 -> Bus_err pulse, write commits 0x7777.
//    CE=1 with strobes low -> no commit, Rd_valid=0.
// 6. Reset asserted in WR1 of a write to 0x0050 -> RAM[0x50] unchanged.
//    All outputs are at reset values the next cycle.

Source files
------------

// File: rtl/sram_responder_if.sv
// SLC-3 memory bus between the CPU control unit and the memory responder.
// Strobes are active low; CPU is the master, memory is the slave.
interface sram_responder_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       ADDR;
    logic [DATA_W-1:0] Data_to_mem;
    logic              Mem_CE;
    logic              Mem_OE;
    logic              Mem_WE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic [DATA_W-1:0] Data_from_mem;
    logic              Rd_valid;
    logic              Wr_done;
    logic              Bus_err;

    modport master (
        output ADDR, Data_to_mem,
        output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
        input  Data_from_mem, Rd_valid, Wr_done, Bus_err
    );

    modport slave (
        input  ADDR, Data_to_mem,
        input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB,
        output Data_from_mem, Rd_valid, Wr_done, Bus_err
    );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the SLC-3 bus: on-chip RAM plus one MMIO word
// (switches on read, hex display register on write).
module sram_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          DATA_W     = 16,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_responder_if.slave   bus,
    input  logic [DATA_W-1:0] Switches,
    output logic [DATA_W-1:0] Hex_out
);
    localparam int HW = DATA_W / 2;

    typedef enum logic [1:0] {IDLE, RD, WR1, WR_HOLD} state_t;

    state_t            state;
    logic [DATA_W-1:0] ram [2**DEPTH_LOG2];

    logic [15:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ub;
    logic              wr_lb;

    logic              commit;
    logic              io_wr;
    logic [DATA_W-1:0] rd_word;

    // A commit happens on the second WE-low edge of a run; reset wins.
    assign commit  = !Reset && !bus.Mem_CE && !bus.Mem_WE && (state == WR1);
    assign io_wr   = (wr_addr == IO_ADDR);
    assign rd_word = (bus.ADDR == IO_ADDR) ? Switches
                   : ram[bus.ADDR[DEPTH_LOG2-1:0]];

    always_ff @(posedge Clk) begin
        if (commit && !io_wr) begin
            if (!wr_lb) ram[wr_addr[DEPTH_LOG2-1:0]][HW-1:0]      <= wr_data[HW-1:0];
            if (!wr_ub) ram[wr_addr[DEPTH_LOG2-1:0]][DATA_W-1:HW] <= wr_data[DATA_W-1:HW];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state             <= IDLE;
            bus.Data_from_mem <= '0;
            bus.Rd_valid      <= 1'b0;
            bus.Wr_done       <= 1'b0;
            bus.Bus_err       <= 1'b0;
            Hex_out           <= '0;
            wr_addr           <= '0;
            wr_data           <= '0;
            wr_ub             <= 1'b1;
            wr_lb             <= 1'b1;
        end else begin
            bus.Wr_done <= 1'b0;
            bus.Bus_err <= 1'b0;
            if (bus.Mem_CE) begin
                state        <= IDLE;
                bus.Rd_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, RD: begin
                        if (!bus.Mem_WE) begin
                            state        <= WR1;
                            bus.Rd_valid <= 1'b0;
                            bus.Bus_err  <= !bus.Mem_OE;
                            wr_addr      <= bus.ADDR;
                            wr_data      <= bus.Data_to_mem;
                            wr_ub        <= bus.Mem_UB;
                            wr_lb        <= bus.Mem_LB;
                        end else if (!bus.Mem_OE) begin
                            state             <= RD;
                            bus.Rd_valid      <= 1'b1;
                            bus.Data_from_mem <= rd_word;
                        end else begin
                            state        <= IDLE;
                            bus.Rd_valid <= 1'b0;
                        end
                    end
                    WR1: begin
                        if (!bus.Mem_WE) begin
                            state       <= WR_HOLD;
                            bus.Wr_done <= 1'b1;
                            if (io_wr) begin
                                if (!wr_lb) Hex_out[HW-1:0]      <= wr_data[HW-1:0];
                                if (!wr_ub) Hex_out[DATA_W-1:HW] <= wr_data[DATA_W-1:HW];
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WR_HOLD: begin
                        if (bus.Mem_WE) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed vector table plus randomized bus
// traffic compared against a run-length based reference model.
module tb_sram_responder;
    logic        Clk;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] Hex_out;

    sram_responder_if #(.DATA_W(16)) bus ();

    sram_responder #(
        .DEPTH_LOG2(10),
        .DATA_W    (16),
        .IO_ADDR   (16'hFFFF)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .bus     (bus),
        .Switches(Switches),
        .Hex_out (Hex_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks;
    int failures;

    // Reference model state: a WE-low run commits on its 2nd edge; the
    // edge that ends a write run does nothing else.
    logic [15:0] mm [int];
    int          we_run;
    logic [15:0] l_addr, l_data;
    logic        l_ub, l_lb;
    logic [15:0] m_dout, m_hex;
    logic        m_v, m_wd, m_be;

    function automatic logic [15:0] merge(input logic [15:0] old, nw,
                                          input logic ub, lb);
        logic [15:0] r;
        r = old;
        if (!lb) r[7:0]  = nw[7:0];
        if (!ub) r[15:8] = nw[15:8];
        return r;
    endfunction

    function automatic void model(input logic r, ce, oe, we, ub, lb,
                                  input logic [15:0] a, din, s);
        int k;
        m_wd = 1'b0;
        m_be = 1'b0;
        if (r) begin
            m_dout = '0; m_hex = '0; m_v = 1'b0; we_run = 0;
        end else if (ce) begin
            we_run = 0; m_v = 1'b0;
        end else if (!we) begin
            m_v = 1'b0;
            we_run++;
            if (we_run == 1) begin
                l_addr = a; l_data = din; l_ub = ub; l_lb = lb;
                m_be = !oe;
            end
            if (we_run == 2) begin
                m_wd = 1'b1;
                if (l_addr == 16'hFFFF) begin
                    m_hex = merge(m_hex, l_data, l_ub, l_lb);
                end else begin
                    k = int'(l_addr[9:0]);
                    mm[k] = merge(mm[k], l_data, l_ub, l_lb);
                end
            end
        end else if (we_run > 0) begin
            we_run = 0; m_v = 1'b0;
        end else if (!oe) begin
            m_v = 1'b1;
            m_dout = (a == 16'hFFFF) ? s : mm[int'(a[9:0])];
        end else begin
            m_v = 1'b0;
        end
    endfunction

    task automatic chk(input string n, input logic [15:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, ce, oe, we, ub, lb,
                        input logic [15:0] a, din, s);
        Reset = r; bus.Mem_CE = ce; bus.Mem_OE = oe; bus.Mem_WE = we;
        bus.Mem_UB = ub; bus.Mem_LB = lb; bus.ADDR = a;
        bus.Data_to_mem = din; Switches = s;
        @(posedge Clk);
        model(r, ce, oe, we, ub, lb, a, din, s);
        #1;
        chk("mdl_rd_valid", {15'd0, bus.Rd_valid}, {15'd0, m_v});
        chk("mdl_dout", bus.Data_from_mem, m_dout);
        chk("mdl_wr_done", {15'd0, bus.Wr_done}, {15'd0, m_wd});
        chk("mdl_bus_err", {15'd0, bus.Bus_err}, {15'd0, m_be});
        chk("mdl_hex", Hex_out, m_hex);
    endtask

    task automatic wr(input logic [15:0] a, d);
        step(0, 0, 1, 0, 0, 0, a, d, 16'h0);
        step(0, 0, 1, 0, 0, 0, a, d, 16'h0);
        step(0, 0, 1, 1, 0, 0, a, d, 16'h0);
    endtask

    typedef struct {
        logic        r, ce, oe, we, ub, lb;
        logic [15:0] a, din;
        logic        v, cd;
        logic [15:0] d;
        logic        wd, be;
        logic [15:0] hex;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, ce, oe, we, ub, lb,
                       input logic [15:0] a, din,
                       input logic v, cd, input logic [15:0] d,
                       input logic wd, be, input logic [15:0] hex);
        vec_t e;
        e.r = r; e.ce = ce; e.oe = oe; e.we = we; e.ub = ub; e.lb = lb;
        e.a = a; e.din = din; e.v = v; e.cd = cd; e.d = d;
        e.wd = wd; e.be = be; e.hex = hex;
        tbl.push_back(e);
    endtask

    logic [15:0] pool [9];

    initial begin
        checks = 0; failures = 0;
        we_run = 0; m_dout = '0; m_hex = '0;
        m_v = 0; m_wd = 0; m_be = 0;
        pool = '{16'h0003, 16'h0010, 16'h0020, 16'h0040, 16'h0050,
                 16'h03FF, 16'h0100, 16'h07FF, 16'hFFFF};

        // Reset, then preload every RAM word the bench touches.
        step(1, 0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0);
        wr(16'h0003, 16'h0303); wr(16'h0010, 16'h1010);
        wr(16'h0020, 16'h2020); wr(16'h0040, 16'h4040);
        wr(16'h0050, 16'h5050); wr(16'h03FF, 16'h3FF3);
        wr(16'h0100, 16'h0101);

        //   r ce oe we ub lb addr      din        v cd d          wd be hex
        add(1, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0003, 16'h0000, 1, 1, 16'h0303, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0003, 16'h0000, 1, 1, 16'h0303, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0003, 16'h0000, 0, 1, 16'h0303, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 1, 1, 16'hBEEF, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 1, 0, 16'h0010, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 1, 0, 16'h0010, 16'h1234, 0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 1, 1, 1, 0, 16'h0010, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 1, 1, 16'hBE34, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0020, 16'h0000, 1, 1, 16'h2020, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 1, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0020, 16'h0000, 1, 1, 16'hAAAA, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'hFFFF, 16'h0000, 1, 1, 16'h5A5A, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'hFFFF, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'hFFFF, 16'h00C3, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 0, 0, 0, 16'hFFFF, 16'h00C3, 0, 0, 16'h0000, 1, 0, 16'h00C3);
        add(0, 0, 1, 1, 0, 0, 16'hFFFF, 16'h00C3, 0, 0, 16'h0000, 0, 0, 16'h00C3);
        add(0, 0, 0, 1, 0, 0, 16'h03FF, 16'h0000, 1, 1, 16'h3FF3, 0, 0, 16'h00C3);
        add(0, 0, 1, 1, 0, 0, 16'h03FF, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h00C3);
        add(0, 0, 0, 0, 0, 0, 16'h0040, 16'h7777, 0, 0, 16'h0000, 0, 1, 16'h00C3);
        add(0, 0, 0, 0, 0, 0, 16'h0040, 16'h7777, 0, 0, 16'h0000, 1, 0, 16'h00C3);
        add(0, 0, 1, 1, 0, 0, 16'h0040, 16'h7777, 0, 0, 16'h0000, 0, 0, 16'h00C3);
        add(0, 0, 0, 1, 0, 0, 16'h0040, 16'h0000, 1, 1, 16'h7777, 0, 0, 16'h00C3);
        add(0, 1, 0, 0, 0, 0, 16'h0040, 16'h1111, 0, 0, 16'h0000, 0, 0, 16'h00C3);
        add(0, 1, 0, 0, 0, 0, 16'h0040, 16'h1111, 0, 0, 16'h0000, 0, 0, 16'h00C3);
        add(0, 0, 1, 1, 0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h00C3);
        add(0, 0, 0, 1, 0, 0, 16'h0040, 16'h0000, 1, 1, 16'h7777, 0, 0, 16'h00C3);
        add(0, 0, 1, 1, 0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h00C3);
        add(0, 0, 1, 0, 0, 0, 16'h0050, 16'hDEAD, 0, 0, 16'h0000, 0, 0, 16'h00C3);
        add(1, 0, 1, 0, 0, 0, 16'h0050, 16'hDEAD, 0, 1, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0050, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0050, 16'h0000, 1, 1, 16'h5050, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0050, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h07FF, 16'h0000, 1, 1, 16'h3FF3, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0003, 16'h0000, 1, 1, 16'h0303, 0, 0, 16'h0000);
        add(0, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 1, 1, 16'hBE34, 0, 0, 16'h0000);
        add(0, 0, 1, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].ce, tbl[i].oe, tbl[i].we, tbl[i].ub,
                 tbl[i].lb, tbl[i].a, tbl[i].din, 16'h5A5A);
            chk($sformatf("vec%0d_rd_valid", i), {15'd0, bus.Rd_valid}, {15'd0, tbl[i].v});
            if (tbl[i].cd)
                chk($sformatf("vec%0d_dout", i), bus.Data_from_mem, tbl[i].d);
            chk($sformatf("vec%0d_wr_done", i), {15'd0, bus.Wr_done}, {15'd0, tbl[i].wd});
            chk($sformatf("vec%0d_bus_err", i), {15'd0, bus.Bus_err}, {15'd0, tbl[i].be});
            chk($sformatf("vec%0d_hex", i), Hex_out, tbl[i].hex);
        end

        // Random bus traffic; strobes tend to persist to form real runs.
        begin
            logic oe, we, ub, lb, ce, r;
            logic [15:0] a, d;
            oe = 1; we = 1; ub = 0; lb = 0; a = 16'h0003; d = 16'h0;
            for (int n = 0; n < 3000; n++) begin
                r  = ($urandom_range(99) == 0);
                ce = ($urandom_range(19) == 0);
                if ($urandom_range(3) == 0) oe = $urandom_range(1);
                if ($urandom_range(3) == 0) we = $urandom_range(1);
                if ($urandom_range(2) == 0) begin
                    a  = pool[$urandom_range(8)];
                    d  = 16'($urandom);
                    ub = $urandom_range(1);
                    lb = $urandom_range(1);
                end
                step(r, ce, oe, we, ub, lb, a, d, 16'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
